glyph_row_reader: RTL

- Read-side master for the 128x1 synchronous glyph ROMs: 8 columns x 16 rows, 1 bit per address, registered output.
- On a start pulse it walks the ROM address space and packs each group of 8 bits into a row byte, MSB = leftmost pixel.
- It presents rows one at a time on a valid/ready interface to the downstream display/scan logic.
- The ROM's one-cycle read latency is absorbed internally.

---
 rtl/glyph_row_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/glyph_row_reader.sv
// glyph_row_reader
// Reads a full glyph out of a 128x1 synchronous ROM (one pixel per address,
// registered output) and hands it downstream one packed row at a time.
// The leftmost pixel of a row lands in the MSB of row_data.
//
// Ports:
//   clock        system clock, everything on the rising edge
//   reset        synchronous, active-high
//   start        one-cycle request to read a glyph (ignored unless idle)
//   rom_address  registered ROM address
//   rom_q        ROM data for the address presented in the previous cycle
//   row_data     packed row, pixel k of the row on bit ROW_W-1-k
//   row_idx      index of the row on row_data
//   row_last     marks the final row of the glyph (qualified by row_valid)
//   row_valid    row_data/row_idx/row_last are valid
//   row_ready    downstream accepts the row on row_valid & row_ready
//   busy         a glyph read is in progress
//   done         one-cycle pulse after the last row has been accepted
//
// ROW_W*ROWS must equal 2**ADDR_W.
module glyph_row_reader #(
  parameter int ROW_W  = 8,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_q,
  output logic [ROW_W-1:0]  row_data,
  output logic [3:0]        row_idx,
  output logic              row_last,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              done
);

  // Counters must be able to hold ROW_W itself ("all addresses issued").
  localparam int CNT_W = $clog2(ROW_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    issue_cnt_reg;   // addresses issued for the current row
  logic [CNT_W-1:0]    cap_cnt_reg;     // pixels captured for the current row
  logic                tag_reg;         // rom_q carries a pixel of this row
  logic [ROW_W-1:0]    shift_reg;
  logic [3:0]          row_reg;

  logic                issuing;
  logic                last_capture;
  logic                last_row;
  logic                load_row;
  logic [3:0]          row_next;
  logic [ADDR_W-1:0]   row_base;

  // An address goes out in each of the first ROW_W cycles of a fetch.
  assign issuing      = (state_reg == ST_FETCH) && (issue_cnt_reg != CNT_W'(ROW_W));
  assign last_capture = tag_reg && (cap_cnt_reg == CNT_W'(ROW_W - 1));
  assign last_row     = (row_reg == 4'(ROWS - 1));
  assign row_base     = ADDR_W'(row_next) * ADDR_W'(ROW_W);

  // Next-state and row-advance decisions.
  always_comb begin
    state_next = state_reg;
    load_row   = 1'b0;
    row_next   = row_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          load_row   = 1'b1;
          row_next   = 4'd0;
        end
      end
      ST_FETCH: begin
        if (last_capture) begin
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (row_ready) begin
          if (last_row) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FETCH;
            load_row   = 1'b1;
            row_next   = row_reg + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address walk, capture pipeline and row packing.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      tag_reg       <= 1'b0;
      shift_reg     <= '0;
      row_reg       <= '0;
    end else begin
      // The tag follows the address by one cycle, matching the ROM latency.
      tag_reg <= issuing;

      if (load_row) begin
        // The first address of the new row must already be on the bus in
        // the first fetch cycle, so it is loaded on the entry edge.
        addr_reg      <= row_base;
        issue_cnt_reg <= '0;
        cap_cnt_reg   <= '0;
        row_reg       <= row_next;
      end else if (issuing) begin
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
        // Stop on the last column so the bus never runs past the row
        // (and never past the top of the ROM on the final row).
        if (issue_cnt_reg != CNT_W'(ROW_W - 1)) begin
          addr_reg <= addr_reg + ADDR_W'(1);
        end
      end

      if (tag_reg) begin
        shift_reg   <= {shift_reg[ROW_W-2:0], rom_q};
        cap_cnt_reg <= cap_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign rom_address = addr_reg;
  assign row_data    = shift_reg;
  assign row_idx     = row_reg;
  assign row_valid   = (state_reg == ST_PRESENT);
  assign row_last    = row_valid && last_row;
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_PRESENT);
  assign done        = (state_reg == ST_DONE);

endmodule
